// File: rtl/vec_popcnt_acc.sv
// Per-vector popcount accumulator: sums the 1 bits of SUB_VEC_NO bus words and emits one tagged count.
// Optional build macro VEC_POPCNT_PADMASK_EN zeroes the pad bits of the last beat before counting.
module vec_popcnt_acc #(
    parameter int BUS_WIDTH    = 128,
    parameter int VECTOR_WIDTH = 920,
    parameter int VEC_ID_WIDTH = 8,
    parameter int SUB_VEC_NO   = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
    parameter int CNT_WIDTH    = $clog2(SUB_VEC_NO * BUS_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUS_WIDTH-1:0]    up_Vector,
    input  logic [VEC_ID_WIDTH-1:0] up_VecID,
    input  logic                    up_Valid,
    input  logic                    up_Last,
    output logic                    up_Ready,
    output logic [CNT_WIDTH-1:0]    dn_Count,
    output logic [VEC_ID_WIDTH-1:0] dn_VecID,
    output logic                    dn_Valid,
    output logic                    dn_Last,
    input  logic                    dn_Ready
);

    localparam int SLICES = BUS_WIDTH / 32;
    localparam int SVC_W  = (SUB_VEC_NO > 1) ? $clog2(SUB_VEC_NO) : 1;
    localparam logic [SVC_W-1:0] LAST_BEAT = SVC_W'(SUB_VEC_NO - 1);

    // Handshake: a transfer happens on a posedge where valid and ready are both 1.
    // The producer holds its payload stable while valid=1 and ready=0; ready never
    // depends on the same side's valid. Here up_Ready = ~(dn_Valid & ~dn_Ready).
    logic stall;
    logic accept;
    assign stall    = dn_Valid & ~dn_Ready;
    assign up_Ready = ~stall;
    assign accept   = up_Valid & up_Ready;

    function automatic logic [5:0] pop32(input logic [31:0] w);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + {5'd0, w[i]};
        return c;
    endfunction

    logic [SVC_W-1:0] sv_cnt;
    logic             at_last_beat;
    logic             beat_final;
    assign at_last_beat = (sv_cnt == LAST_BEAT);
    assign beat_final   = at_last_beat | up_Last;

    logic [BUS_WIDTH-1:0] count_word;
`ifdef VEC_POPCNT_PADMASK_EN
    localparam int DELTA = SUB_VEC_NO * BUS_WIDTH - VECTOR_WIDTH;
    logic [BUS_WIDTH-1:0] pad_mask;
    always_comb begin
        pad_mask = '0;
        for (int i = 0; i < BUS_WIDTH; i++)
            if (i < DELTA) pad_mask[i] = 1'b1;
    end
    // Only a full-length last beat carries pad; early-closed beats are counted as-is.
    assign count_word = at_last_beat ? (up_Vector & ~pad_mask) : up_Vector;
`else
    assign count_word = up_Vector;
`endif

    logic [5:0] part [SLICES];
    always_comb begin
        for (int i = 0; i < SLICES; i++) part[i] = pop32(count_word[i*32 +: 32]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sv_cnt <= '0;
        end else if (accept) begin
            sv_cnt <= beat_final ? '0 : sv_cnt + SVC_W'(1);
        end
    end

    // S1: slice partials plus the beat's tag
    logic                    s1_valid;
    logic [5:0]              s1_part [SLICES];
    logic [VEC_ID_WIDTH-1:0] s1_id;
    logic                    s1_last;
    logic                    s1_final;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_last  <= 1'b0;
            s1_final <= 1'b0;
            for (int i = 0; i < SLICES; i++) s1_part[i] <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_id    <= up_VecID;
                s1_last  <= up_Last;
                s1_final <= beat_final;
                for (int i = 0; i < SLICES; i++) s1_part[i] <= part[i];
            end
        end
    end

    // S2: fold the word count into the running total or close the vector
    logic [CNT_WIDTH-1:0] word_cnt;
    logic [CNT_WIDTH-1:0] acc;

    always_comb begin
        word_cnt = '0;
        for (int i = 0; i < SLICES; i++) word_cnt = word_cnt + CNT_WIDTH'(s1_part[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            dn_Count <= '0;
            dn_VecID <= '0;
            dn_Last  <= 1'b0;
            dn_Valid <= 1'b0;
        end else if (!stall) begin
            // Without stall the current output is either absent or consumed this edge.
            dn_Valid <= s1_valid & s1_final;
            if (s1_valid) begin
                if (s1_final) begin
                    dn_Count <= acc + word_cnt;
                    dn_VecID <= s1_id;
                    dn_Last  <= s1_last;
                    acc      <= '0;
                end else begin
                    acc <= acc + word_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_popcnt_acc.sv
// Directed bench for vec_popcnt_acc: hand-computed counts pushed to an expected queue and
// checked against every dn_* handshake.
module tb_vec_popcnt_acc;

  localparam int BW  = 128;
  localparam int IDW = 8;
  localparam int CW  = 11;
  localparam int W   = 1 + IDW + CW;

`ifdef VEC_POPCNT_PADMASK_EN
  localparam int PAD_EXP = 920;
`else
  localparam int PAD_EXP = 1024;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [BW-1:0]  up_Vector = '0;
  logic [IDW-1:0] up_VecID = '0;
  logic           up_Valid = 1'b0;
  logic           up_Last = 1'b0;
  logic           up_Ready;
  logic [CW-1:0]  dn_Count;
  logic [IDW-1:0] dn_VecID;
  logic           dn_Valid;
  logic           dn_Last;
  logic           dn_Ready = 1'b1;

  vec_popcnt_acc dut (
    .clk      (clk),
    .rst      (rst),
    .up_Vector(up_Vector),
    .up_VecID (up_VecID),
    .up_Valid (up_Valid),
    .up_Last  (up_Last),
    .up_Ready (up_Ready),
    .dn_Count (dn_Count),
    .dn_VecID (dn_VecID),
    .dn_Valid (dn_Valid),
    .dn_Last  (dn_Last),
    .dn_Ready (dn_Ready)
  );

  // clock/reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cycles = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_e;
  logic [BW-1:0] vbuf [8];
  logic [BW-1:0] ones;
  logic [BW-1:0] pad_word;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int cnt, input int id, input logic last);
    exp_q.push_back({last, IDW'(id), CW'(cnt)});
  endtask

  // driver: present one word and hold it until up_Ready is seen at the edge
  task automatic send_word(input logic [BW-1:0] vec, input logic [IDW-1:0] id, input logic last);
    int waits = 0;
    up_Vector = vec;
    up_VecID  = id;
    up_Last   = last;
    up_Valid  = 1'b1;
    @(negedge clk);
    while (!up_Ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    stall_cycles += waits;
    if (!up_Ready) check_eq("up_Ready_timeout", 32'(up_Ready), 32'd1);
    @(posedge clk);
    #1;
    up_Valid = 1'b0;
  endtask

  task automatic send_vec(input logic [IDW-1:0] id, input int n, input logic last_at_end);
    for (int i = 0; i < n; i++) send_word(vbuf[i], id, last_at_end && (i == n - 1));
  endtask

  task automatic fill_full;
    for (int i = 0; i < 7; i++) vbuf[i] = ones;
    vbuf[7] = pad_word;
  endtask

  // scoreboard: every downstream transfer must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && dn_Valid && dn_Ready) begin
      if (exp_q.size() == 0) begin
        check_eq("dn_unexpected", 32'(dn_Valid), 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check_eq("dn_Count", 32'(dn_Count), 32'(exp_e[CW-1:0]));
        check_eq("dn_VecID", 32'(dn_VecID), 32'(exp_e[CW +: IDW]));
        check_eq("dn_Last",  32'(dn_Last),  32'(exp_e[W-1]));
      end
    end
  end

  initial begin
    ones     = '1;
    pad_word = {24'hFF_FFFF, 104'h0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dn_Valid", 32'(dn_Valid), 32'd0);
    check_eq("rst_dn_Count", 32'(dn_Count), 32'd0);
    check_eq("rst_dn_VecID", 32'(dn_VecID), 32'd0);
    check_eq("rst_dn_Last",  32'(dn_Last),  32'd0);
    check_eq("rst_up_Ready", 32'(up_Ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // defaults: 920-bit vector, ID 3, plus output latency
    fill_full();
    push_exp(920, 3, 1'b1);
    send_vec(8'd3, 8, 1'b1);
    check_eq("lat_edge1_valid", 32'(dn_Valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("lat_edge2_valid", 32'(dn_Valid), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // back-to-back: zero vector then word k with k+1 ones (1+2+...+8 = 36)
    stall_cycles = 0;
    for (int k = 0; k < 8; k++) vbuf[k] = '0;
    push_exp(0, 5, 1'b0);
    send_vec(8'd5, 8, 1'b0);
    for (int k = 0; k < 8; k++) vbuf[k] = (128'd1 << (k + 1)) - 128'd1;
    push_exp(36, 6, 1'b1);
    send_vec(8'd6, 8, 1'b1);
    check_eq("b2b_stall_cycles", 32'(stall_cycles), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // backpressure: hold 920/ID 7 while the next vector (7*64 + 12 = 460) queues up
    dn_Ready = 1'b0;
    fill_full();
    push_exp(920, 7, 1'b1);
    send_vec(8'd7, 8, 1'b1);
    for (int k = 0; k < 7; k++) vbuf[k] = {4{32'h0F0F_0F0F}};
    vbuf[7] = {24'h0F_0F0F, 104'h0};
    push_exp(460, 9, 1'b1);
    fork
      send_vec(8'd9, 8, 1'b1);
      begin
        int w = 0;
        @(negedge clk);
        while (!dn_Valid && w < 20) begin
          w++;
          @(negedge clk);
        end
        check_eq("bp_valid_rise", 32'(dn_Valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
          check_eq("bp_hold_valid", 32'(dn_Valid), 32'd1);
          check_eq("bp_hold_count", 32'(dn_Count), 32'd920);
          check_eq("bp_hold_id",    32'(dn_VecID), 32'd7);
          check_eq("bp_up_Ready",   32'(up_Ready), 32'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        dn_Ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // early close after 3 full words, then a full vector starting at beat 0
    for (int k = 0; k < 3; k++) vbuf[k] = ones;
    push_exp(384, 11, 1'b1);
    send_vec(8'd11, 3, 1'b1);
    fill_full();
    push_exp(920, 12, 1'b1);
    send_vec(8'd12, 8, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // reset after 4 words: aborted vector must not appear
    for (int k = 0; k < 8; k++) vbuf[k] = ones;
    send_vec(8'd13, 4, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("mid_rst_dn_Valid", 32'(dn_Valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst_dn_Valid", 32'(dn_Valid), 32'd0);
    fill_full();
    push_exp(920, 14, 1'b1);
    send_vec(8'd14, 8, 1'b1);

    // non-zero pad on the last beat
    for (int k = 0; k < 8; k++) vbuf[k] = ones;
    push_exp(PAD_EXP, 15, 1'b1);
    send_vec(8'd15, 8, 1'b1);

    begin
      int w = 0;
      while (exp_q.size() != 0 && w < 50) begin
        w++;
        @(posedge clk);
      end
    end
    @(negedge clk);
    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
